// File: rtl/exp_accum.sv
// Frame accumulator for exp-stage results: sums unsigned 5.5 beats per frame and holds the result for a handshake.
// Optional saturation on overflow is enabled by defining EXP_ACCUM_SAT_EN; the default build wraps.
module exp_accum #(
  parameter int SUM_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_run;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic [SUM_W-1:0] w_sum_next;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_accept;
  logic             w_release;
  logic             w_term;

  assign w_accept    = in_valid && in_ready;
  assign w_release   = out_valid && out_ready;
  assign w_count_inc = r_count + CNT_ONE;
  // A frame closes on in_last or when the counter would otherwise exceed its range.
  assign w_term      = w_accept && (in_last || (w_count_inc == CNT_MAX));

`ifdef EXP_ACCUM_SAT_EN
  logic [SUM_W:0] w_add;
  logic           r_ovf;

  assign w_add      = {1'b0, r_sum} + {{(SUM_W-9){1'b0}}, in_data};
  assign w_sum_next = w_add[SUM_W] ? {SUM_W{1'b1}} : w_add[SUM_W-1:0];
  assign out_ovf    = r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_release) begin
      r_ovf <= 1'b0;
    end else if (w_accept && w_add[SUM_W]) begin
      r_ovf <= 1'b1;
    end
  end
`else
  assign w_sum_next = r_sum + {{(SUM_W-10){1'b0}}, in_data};
  assign out_ovf    = 1'b0;
`endif

  // r_run keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (w_release) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_sum   <= w_sum_next;
      r_count <= w_count_inc;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_ACC: begin
        in_ready = r_run;
        if (w_term) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (w_release) begin
          w_state_next = ST_ACC;
        end
      end
      default: w_state_next = ST_ACC;
    endcase
  end

  assign out_sum   = r_sum;
  assign out_count = r_count;

endmodule

// File: tb/tb_exp_accum.sv
// Self-checking bench for exp_accum: scoreboard of expected frame results, one task per scenario.
module tb_exp_accum;

`ifdef EXP_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int MAXC = 255;

  typedef struct {
    logic [15:0] sum;
    logic [7:0]  count;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  int   errors = 0;
  int   checks = 0;
  int   m_true = 0;
  int   m_cnt  = 0;
  exp_t sb_q[$];

  exp_accum #(.SUM_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  function automatic void model_close();
    exp_t e;
    e.count = m_cnt[7:0];
    if (SAT && m_true > 65535) begin
      e.sum = 16'hFFFF;
      e.ovf = 1'b1;
    end else begin
      e.sum = m_true[15:0];
      e.ovf = 1'b0;
    end
    sb_q.push_back(e);
    m_true = 0;
    m_cnt  = 0;
  endfunction

  task automatic drive_beat(input logic [9:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_true += int'(d);
    m_cnt++;
    if (last || m_cnt == MAXC) model_close();
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data  = 10'($urandom_range(0, 1023));
      in_last  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_last = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    for (int i = 0; i < 400 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    ok = out_valid;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_sum !== 16'h0) begin errors++; $display("FAIL reset_sum got=%h want=0000", out_sum); end
    checks++; if (out_count !== 8'h0) begin errors++; $display("FAIL reset_count got=%0d want=0", out_count); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", out_ovf); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_before_edge got=%b want=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after_edge got=%b want=1", in_ready); end
    $display("test_reset done: in_ready=%b", in_ready);
  endtask

  task automatic test_basic();
    bit   ok;
    exp_t e;
    for (int b = 0; b < 4; b++) begin
      drive_beat(10'h020, b == 3);
      if (b < 3) drive_idle(1);
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid=%b want=1", out_valid); end
    wait_out(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || {out_sum, out_count, out_ovf} !== {e.sum, e.count, e.ovf}) begin
      errors++;
      $display("FAIL basic_result got sum=%h cnt=%0d ovf=%b want sum=%h cnt=%0d ovf=%b", out_sum, out_count, out_ovf, e.sum, e.count, e.ovf);
    end
    $display("test_basic: sum=%h count=%0d ovf=%b", out_sum, out_count, out_ovf);
    handshake();
  endtask

  task automatic test_backpressure();
    bit   ok;
    exp_t e;
    drive_beat(10'h030, 1'b0);
    drive_beat(10'h030, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle=%0d got=%b want=0", c, in_ready); end
      checks++; if (out_sum !== 16'h0060 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cycle=%0d sum=%h valid=%b want sum=0060 valid=1", c, out_sum, out_valid); end
      @(posedge clk); #1;
    end
    wait_out(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || {out_sum, out_count, out_ovf} !== {e.sum, e.count, e.ovf}) begin
      errors++;
      $display("FAIL bp_result got sum=%h cnt=%0d ovf=%b want sum=%h cnt=%0d ovf=%b", out_sum, out_count, out_ovf, e.sum, e.count, e.ovf);
    end
    handshake();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    $display("test_backpressure: released, in_ready=%b", in_ready);
  endtask

  task automatic test_auto_terminate();
    bit   ok;
    exp_t e;
    for (int b = 0; b < MAXC; b++) begin
      if (b == MAXC - 1) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL auto_ready_before_last got=%b want=1", in_ready); end
      end
      drive_beat(10'h001, 1'b0);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL auto_ready_after got=%b want=0", in_ready); end
    wait_out(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || {out_sum, out_count, out_ovf} !== {e.sum, e.count, e.ovf}) begin
      errors++;
      $display("FAIL auto_result got sum=%h cnt=%0d ovf=%b want sum=%h cnt=%0d ovf=%b", out_sum, out_count, out_ovf, e.sum, e.count, e.ovf);
    end
    $display("test_auto_terminate: sum=%h count=%0d", out_sum, out_count);
    handshake();
  endtask

  task automatic test_overflow();
    bit   ok;
    exp_t e;
    for (int b = 1; b <= 70; b++) begin
      drive_beat(10'h3FF, b == 70);
      if (b == 64) begin
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_beat64 got=%b want=0", out_ovf); end
      end
      if (b == 65) begin
        checks++; if (out_ovf !== SAT) begin errors++; $display("FAIL ovf_beat65 got=%b want=%b", out_ovf, SAT); end
      end
    end
    wait_out(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || {out_sum, out_count, out_ovf} !== {e.sum, e.count, e.ovf}) begin
      errors++;
      $display("FAIL ovf_result got sum=%h cnt=%0d ovf=%b want sum=%h cnt=%0d ovf=%b", out_sum, out_count, out_ovf, e.sum, e.count, e.ovf);
    end
    $display("test_overflow: sum=%h ovf=%b", out_sum, out_ovf);
    handshake();
  endtask

  task automatic test_reset_mid_frame();
    bit   ok;
    exp_t e;
    for (int b = 0; b < 3; b++) drive_beat(10'h020, 1'b0);
    m_true = 0;
    m_cnt  = 0;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got=%b want=0", in_ready); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid cycle=%0d got=%b want=0", c, out_valid); end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_release ready=%b valid=%b want 1/0", in_ready, out_valid); end
    drive_beat(10'h040, 1'b1);
    wait_out(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || {out_sum, out_count, out_ovf} !== {e.sum, e.count, e.ovf}) begin
      errors++;
      $display("FAIL rstmid_result got sum=%h cnt=%0d ovf=%b want sum=%h cnt=%0d ovf=%b", out_sum, out_count, out_ovf, e.sum, e.count, e.ovf);
    end
    $display("test_reset_mid_frame: sum=%h count=%0d", out_sum, out_count);
    handshake();
  endtask

  task automatic test_single_beat();
    bit   ok;
    exp_t e;
    drive_beat(10'h3FF, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency out_valid=%b want=1", out_valid); end
    wait_out(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || {out_sum, out_count, out_ovf} !== {e.sum, e.count, e.ovf}) begin
      errors++;
      $display("FAIL single_result got sum=%h cnt=%0d ovf=%b want sum=%h cnt=%0d ovf=%b", out_sum, out_count, out_ovf, e.sum, e.count, e.ovf);
    end
    $display("test_single_beat: sum=%h count=%0d", out_sum, out_count);
    handshake();
  endtask

  task automatic test_back_to_back();
    bit   ok;
    exp_t e;
    int   len;
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        drive_beat(10'($urandom_range(0, 1023)), b == len - 1);
        if (b < len - 1) drive_idle($urandom_range(0, 2));
      end
      wait_out(ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || {out_sum, out_count, out_ovf} !== {e.sum, e.count, e.ovf}) begin
        errors++;
        $display("FAIL b2b_result frame=%0d got sum=%h cnt=%0d ovf=%b want sum=%h cnt=%0d ovf=%b", f, out_sum, out_count, out_ovf, e.sum, e.count, e.ovf);
      end
      $display("test_back_to_back frame %0d: sum=%h count=%0d", f, out_sum, out_count);
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_auto_terminate();
    test_overflow();
    test_reset_mid_frame();
    test_single_beat();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
